// File: rtl/fifo_nibble_reader.sv
// Pairs 4-bit entries from a first-word fall-through FIFO into bytes, flushing a lone nibble after an idle timeout.
// Optional out_parity port enabled by defining READER_PARITY_EN.
module fifo_nibble_reader #(
   parameter int LOW_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       read_clock,
   input  logic       read_reset,
   input  logic       empty,
   input  logic [3:0] read_data,
   output logic       read_increment,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_partial
`ifdef READER_PARITY_EN
   ,
   output logic       out_parity
`endif
);

   typedef enum logic [1:0] {IDLE, HALF, OUT} state_t;

   localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] nib_q, nib_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       out_partial_q, out_partial_d;
   logic       pop;
   logic [7:0] cnt_inc;

   always_comb begin
      state_d       = state_q;
      nib_d         = nib_q;
      cnt_d         = cnt_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_partial_d = out_partial_q;
      pop           = 1'b0;
      // Saturate so a disabled or long timeout never wraps back onto a match.
      cnt_inc       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      case (state_q)
         IDLE: begin
            pop = !empty;
            if (pop) begin
               nib_d   = read_data;
               cnt_d   = 8'd0;
               state_d = HALF;
            end
         end
         HALF: begin
            pop = !empty;
            if (pop) begin
               out_data_d    = (LOW_FIRST != 0) ? {read_data, nib_q} : {nib_q, read_data};
               out_valid_d   = 1'b1;
               out_partial_d = 1'b0;
               cnt_d         = 8'd0;
               state_d       = OUT;
            end else begin
               cnt_d = cnt_inc;
               if ((TIMEOUT != 8'd0) && (cnt_inc == TIMEOUT)) begin
                  out_data_d    = (LOW_FIRST != 0) ? {4'h0, nib_q} : {nib_q, 4'h0};
                  out_valid_d   = 1'b1;
                  out_partial_d = 1'b1;
                  state_d       = OUT;
               end
            end
         end
         OUT: begin
            pop = out_ready && !empty;
            if (out_ready) begin
               out_valid_d   = 1'b0;
               out_partial_d = 1'b0;
               if (!empty) begin
                  nib_d   = read_data;
                  cnt_d   = 8'd0;
                  state_d = HALF;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge read_clock or posedge read_reset) begin
      if (read_reset) begin
         state_q       <= IDLE;
         nib_q         <= 4'h0;
         cnt_q         <= 8'd0;
         out_data_q    <= 8'h00;
         out_valid_q   <= 1'b0;
         out_partial_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         nib_q         <= nib_d;
         cnt_q         <= cnt_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_partial_q <= out_partial_d;
      end
   end

   assign read_increment = pop && !read_reset;
   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign out_partial    = out_partial_q;

`ifdef READER_PARITY_EN
   logic out_parity_q, out_parity_d;

   always_comb out_parity_d = ^out_data_d;

   always_ff @(posedge read_clock or posedge read_reset) begin
      if (read_reset) out_parity_q <= 1'b0;
      else            out_parity_q <= out_parity_d;
   end

   assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_fifo_nibble_reader.sv
// Directed bench: three readers (low-first, high-first, timeout disabled) share one FIFO model; only the selected one sees data.
module tb_fifo_nibble_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             out_ready;
   logic             fifo_empty;
   logic [3:0]       fifo_head;
   logic [1:0]       sel;
   logic [3:0]       q[$];
   logic [2:0]       emp, inc, ov, op;
   logic [2:0][7:0]  od;
`ifdef READER_PARITY_EN
   logic [2:0]       opar;
`endif
   int               n_vec = 0;
   int               n_err = 0;
   int               pops = 0;
   int               bad_pop = 0;

   assign emp[0] = (sel != 2'd0) || fifo_empty;
   assign emp[1] = (sel != 2'd1) || fifo_empty;
   assign emp[2] = (sel != 2'd2) || fifo_empty;

   fifo_nibble_reader #(.LOW_FIRST(1), .TIMEOUT_CYCLES(15)) dut0 (
      .read_clock(clk), .read_reset(rst), .empty(emp[0]), .read_data(fifo_head),
      .read_increment(inc[0]), .out_data(od[0]), .out_valid(ov[0]),
      .out_ready(out_ready), .out_partial(op[0])
`ifdef READER_PARITY_EN
      , .out_parity(opar[0])
`endif
   );

   fifo_nibble_reader #(.LOW_FIRST(0), .TIMEOUT_CYCLES(15)) dut1 (
      .read_clock(clk), .read_reset(rst), .empty(emp[1]), .read_data(fifo_head),
      .read_increment(inc[1]), .out_data(od[1]), .out_valid(ov[1]),
      .out_ready(out_ready), .out_partial(op[1])
`ifdef READER_PARITY_EN
      , .out_parity(opar[1])
`endif
   );

   fifo_nibble_reader #(.LOW_FIRST(1), .TIMEOUT_CYCLES(0)) dut2 (
      .read_clock(clk), .read_reset(rst), .empty(emp[2]), .read_data(fifo_head),
      .read_increment(inc[2]), .out_data(od[2]), .out_valid(ov[2]),
      .out_ready(out_ready), .out_partial(op[2])
`ifdef READER_PARITY_EN
      , .out_parity(opar[2])
`endif
   );

   function automatic void refresh();
      fifo_empty = (q.size() == 0);
      fifo_head  = fifo_empty ? 4'h0 : q[0];
   endfunction

   // FIFO model: consume the head shortly after any edge the selected reader popped on.
   always @(posedge clk) begin
      if ((inc & emp) != 3'b000) bad_pop++;
      if (inc[sel]) begin
         #1;
         if (q.size() != 0) void'(q.pop_front());
         pops++;
         refresh();
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [1:0] s);
      rst = 1'b1;
      sel = s;
      out_ready = 1'b1;
      q.delete();
      refresh();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int base;
      sel = 2'd0; out_ready = 1'b1;
      q.push_back(4'hF); refresh();
      #2 rst = 1'b1;
      #1;
      n_vec++; if (ov[0] !== 1'b0)   begin n_err++; $display("FAIL rst_valid got %b want 0", ov[0]); end
      n_vec++; if (od[0] !== 8'h00)  begin n_err++; $display("FAIL rst_data got %h want 00", od[0]); end
      n_vec++; if (op[0] !== 1'b0)   begin n_err++; $display("FAIL rst_partial got %b want 0", op[0]); end
      n_vec++; if (inc !== 3'b000)   begin n_err++; $display("FAIL rst_pop got %b want 000", inc); end
      base = pops;
      tick(); tick();
      n_vec++; if (pops - base !== 0) begin n_err++; $display("FAIL rst_nopop got %0d want 0", pops - base); end
      rst = 1'b0;
      #1;
      n_vec++; if (inc[0] !== 1'b1)  begin n_err++; $display("FAIL rel_pop_req got %b want 1", inc[0]); end
      n_vec++; if (pops - base !== 0) begin n_err++; $display("FAIL rel_early_pop got %0d want 0", pops - base); end
      tick();
      n_vec++; if (pops - base !== 1) begin n_err++; $display("FAIL rel_first_pop got %0d want 1", pops - base); end
   endtask

   task automatic test_pair();
      int base;
      do_reset(2'd0);
      q.push_back(4'hA); q.push_back(4'h5); refresh();
      base = pops;
      tick();
      n_vec++; if (ov[0] !== 1'b0)   begin n_err++; $display("FAIL pair_half_valid got %b want 0", ov[0]); end
      n_vec++; if (inc[0] !== 1'b1)  begin n_err++; $display("FAIL pair_half_pop got %b want 1", inc[0]); end
      tick();
      n_vec++; if (ov[0] !== 1'b1)   begin n_err++; $display("FAIL pair_valid got %b want 1", ov[0]); end
      n_vec++; if (od[0] !== 8'h5A)  begin n_err++; $display("FAIL pair_data got %h want 5a", od[0]); end
      n_vec++; if (op[0] !== 1'b0)   begin n_err++; $display("FAIL pair_partial got %b want 0", op[0]); end
      n_vec++; if (pops - base !== 2) begin n_err++; $display("FAIL pair_pops got %0d want 2", pops - base); end
`ifdef READER_PARITY_EN
      n_vec++; if (opar[0] !== 1'b0) begin n_err++; $display("FAIL pair_parity got %b want 0", opar[0]); end
`endif
      tick();
      n_vec++; if (ov[0] !== 1'b0)   begin n_err++; $display("FAIL pair_drop got %b want 0", ov[0]); end
   endtask

   task automatic test_high_first();
      do_reset(2'd1);
      q.push_back(4'h3); q.push_back(4'hC); refresh();
      tick(); tick();
      n_vec++; if (ov[1] !== 1'b1)   begin n_err++; $display("FAIL hf_valid got %b want 1", ov[1]); end
      n_vec++; if (od[1] !== 8'h3C)  begin n_err++; $display("FAIL hf_data got %h want 3c", od[1]); end
      tick();
      n_vec++; if (ov[1] !== 1'b0)   begin n_err++; $display("FAIL hf_drop got %b want 0", ov[1]); end
   endtask

   task automatic test_timeout();
      logic early;
      early = 1'b0;
      do_reset(2'd0);
      q.push_back(4'h7); refresh();
      tick();
      for (int i = 2; i <= 15; i++) begin
         tick();
         early |= ov[0];
      end
      n_vec++; if (early !== 1'b0)   begin n_err++; $display("FAIL to_early got %b want 0", early); end
      tick();
      n_vec++; if (ov[0] !== 1'b1)   begin n_err++; $display("FAIL to_valid got %b want 1", ov[0]); end
      n_vec++; if (od[0] !== 8'h07)  begin n_err++; $display("FAIL to_data got %h want 07", od[0]); end
      n_vec++; if (op[0] !== 1'b1)   begin n_err++; $display("FAIL to_partial got %b want 1", op[0]); end
`ifdef READER_PARITY_EN
      n_vec++; if (opar[0] !== 1'b1) begin n_err++; $display("FAIL to_parity got %b want 1", opar[0]); end
`endif
      out_ready = 1'b0;
      tick(); tick();
      n_vec++; if ({ov[0], op[0], od[0]} !== {2'b11, 8'h07})
         begin n_err++; $display("FAIL to_hold got %b%b/%h want 11/07", ov[0], op[0], od[0]); end
      out_ready = 1'b1;
      tick();
      n_vec++; if ({ov[0], op[0]} !== 2'b00)
         begin n_err++; $display("FAIL to_clear got %b%b want 00", ov[0], op[0]); end
   endtask

   task automatic test_timeout_race();
      do_reset(2'd0);
      q.push_back(4'h7); refresh();
      tick();
      for (int i = 2; i <= 15; i++) tick();
      q.push_back(4'h3); refresh();
      tick();
      n_vec++; if (ov[0] !== 1'b1)   begin n_err++; $display("FAIL race_valid got %b want 1", ov[0]); end
      n_vec++; if (od[0] !== 8'h37)  begin n_err++; $display("FAIL race_data got %h want 37", od[0]); end
      n_vec++; if (op[0] !== 1'b0)   begin n_err++; $display("FAIL race_partial got %b want 0", op[0]); end
   endtask

   task automatic test_no_timeout();
      logic seen;
      int   base;
      seen = 1'b0;
      do_reset(2'd2);
      base = pops;
      q.push_back(4'h7); refresh();
      for (int i = 0; i < 300; i++) begin
         tick();
         seen |= ov[2];
      end
      n_vec++; if (seen !== 1'b0)    begin n_err++; $display("FAIL t0_output got %b want 0", seen); end
      n_vec++; if (pops - base !== 1) begin n_err++; $display("FAIL t0_pops got %0d want 1", pops - base); end
   endtask

   task automatic test_back_to_back();
      int         base;
      logic       exp_v [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] exp_d [7] = '{8'h00, 8'h43, 8'h00, 8'h65, 8'h00, 8'h87, 8'h00};
      do_reset(2'd0);
      for (int n = 1; n <= 8; n++) q.push_back(4'(n));
      refresh();
      base = pops;
      tick(); tick();
      n_vec++; if (od[0] !== 8'h21)  begin n_err++; $display("FAIL b2b_first got %h want 21", od[0]); end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if ({ov[0], od[0]} !== {1'b1, 8'h21})
            begin n_err++; $display("FAIL b2b_hold%0d got %b/%h want 1/21", i, ov[0], od[0]); end
         n_vec++; if (pops - base !== 2)
            begin n_err++; $display("FAIL b2b_holdpop%0d got %0d want 2", i, pops - base); end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_vec++; if (ov[0] !== exp_v[i])
            begin n_err++; $display("FAIL b2b_valid%0d got %b want %b", i, ov[0], exp_v[i]); end
         if (exp_v[i]) begin
            n_vec++; if (od[0] !== exp_d[i])
               begin n_err++; $display("FAIL b2b_data%0d got %h want %h", i, od[0], exp_d[i]); end
         end
      end
      n_vec++; if (pops - base !== 8) begin n_err++; $display("FAIL b2b_pops got %0d want 8", pops - base); end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset(2'd0);
      q.push_back(4'h1); q.push_back(4'h2); refresh();
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      n_vec++; if ({ov[0], op[0], od[0]} !== 10'd0)
         begin n_err++; $display("FAIL mid_out_async got %b%b/%h want 00/00", ov[0], op[0], od[0]); end
      @(negedge clk);
      rst = 1'b0;
      q.push_back(4'h9); refresh();
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      n_vec++; if ({ov[0], op[0], od[0]} !== 10'd0)
         begin n_err++; $display("FAIL mid_half_async got %b%b/%h want 00/00", ov[0], op[0], od[0]); end
      base = pops;
      q.push_back(4'h1); q.push_back(4'h2); refresh();
      #1;
      n_vec++; if (inc[0] !== 1'b0)  begin n_err++; $display("FAIL mid_pop_in_rst got %b want 0", inc[0]); end
      @(negedge clk);
      n_vec++; if (pops - base !== 0) begin n_err++; $display("FAIL mid_rst_pops got %0d want 0", pops - base); end
      rst = 1'b0;
      tick(); tick();
      n_vec++; if (ov[0] !== 1'b1)   begin n_err++; $display("FAIL mid_valid got %b want 1", ov[0]); end
      n_vec++; if (od[0] !== 8'h21)  begin n_err++; $display("FAIL mid_data got %h want 21", od[0]); end
      n_vec++; if (op[0] !== 1'b0)   begin n_err++; $display("FAIL mid_partial got %b want 0", op[0]); end
   endtask

   initial begin
      rst = 1'b0; sel = 2'd0; out_ready = 1'b0;
      fifo_empty = 1'b1; fifo_head = 4'h0;
      test_reset();
      test_pair();
      test_high_first();
      test_timeout();
      test_timeout_race();
      test_no_timeout();
      test_back_to_back();
      test_reset_mid();
      n_vec++; if (bad_pop !== 0) begin n_err++; $display("FAIL pop_while_empty got %0d want 0", bad_pop); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_nibble_reader.md
FIFO_NIBBLE_READER -- requirements
Module: fifo_nibble_reader

Interface
REQ-001 The block SHALL have these parameters: LOW_FIRST, default 1, first popped nibble lands in out_data[3:0] (0: lands in out_data[7:4]).
REQ-002 The block SHALL have this parameter: TIMEOUT_CYCLES, default 15, range 0..255, idle cycles before a partial byte is flushed (0 disables flush).
REQ-003 The block SHALL have this port: read_clock, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have this port: read_reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have this port: empty, input, 1, FIFO read-side empty flag.
REQ-006 The block SHALL have this port: read_data, input, 4, FIFO head entry, valid whenever empty=0 (first-word fall-through).
REQ-007 The block SHALL have this port: read_increment, output, 1, FIFO pop strobe, one entry consumed per cycle high.
REQ-008 The block SHALL have this port: out_data, output, 8, assembled byte, registered.
REQ-009 The block SHALL have this port: out_valid, output, 1, out_data holds a byte, registered.
REQ-010 The block SHALL have this port: out_ready, input, 1, consumer accepts the byte this cycle.
REQ-011 The block SHALL have this port: out_partial, output, 1, the current byte is a timeout flush with one nibble only, registered.

Function
REQ-012 The block SHALL implement the FSM states IDLE (no nibble held), HALF (first nibble held) and OUT (byte presented).
REQ-013 read_increment SHALL be combinational and equal !empty in IDLE, !empty in HALF, (out_ready & !empty) in OUT, and 0 while read_reset=1.
REQ-014 On an IDLE pop, the block SHALL register read_data as the first nibble and go to HALF.
REQ-015 On a HALF pop, the block SHALL load out_data from the held nibble and read_data per LOW_FIRST, set out_valid=1 and out_partial=0, and go to OUT.
REQ-016 In HALF, an 8-bit idle counter SHALL increment each cycle empty=1 and SHALL clear on entry to HALF and on every pop.
REQ-017 When the idle counter equals TIMEOUT_CYCLES (nonzero), the block SHALL load out_data with the held nibble in its LOW_FIRST position and zeros elsewhere, set out_valid=1 and out_partial=1, and go to OUT.
REQ-018 In OUT, out_data, out_valid and out_partial SHALL hold stable until out_ready=1.
REQ-019 If out_ready=1 with empty=1 in OUT, the block SHALL clear out_valid and out_partial next cycle and go to IDLE.
REQ-020 If out_ready=1 with empty=0 in OUT, the block SHALL accept the byte, pop the next nibble into the holding register, clear out_valid and go to HALF in the same edge.
REQ-021 Sustained throughput SHALL be one byte per 2 cycles when the FIFO stays non-empty and out_ready=1.
REQ-022 Latency from the first pop to out_valid=1 SHALL be 2 cycles with the FIFO non-empty.
REQ-023 A timeout and a pop in the same HALF cycle SHALL resolve to the pop, with no partial byte.
REQ-024 The block SHALL never pop more than one entry per cycle and never pop while empty=1.

Reset
REQ-025 Asserting read_reset SHALL immediately force IDLE, out_data=0, out_valid=0, out_partial=0, idle counter=0 and held nibble=0, regardless of clock.
REQ-026 Reset mid-operation SHALL discard any held nibble or pending byte without popping.
REQ-027 The first pop SHALL occur no earlier than the first rising edge after read_reset deasserts.

Configuration
REQ-028 With READER_PARITY_EN defined, the block SHALL add an output port out_parity (1 bit, registered) equal to the XOR of out_data, updated with out_data, and reset to 0.
REQ-029 Without READER_PARITY_EN, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then FIFO holds 0xA, 0x5, out_ready=1, LOW_FIRST=1 -> two pops on consecutive cycles, out_data=0x5A, out_valid for 1 cycle, out_partial=0.
REQ-031 The bench SHALL cover this scenario: LOW_FIRST=0, FIFO holds 0x3, 0xC -> out_data=0x3C.
REQ-032 The bench SHALL cover this scenario: FIFO holds only 0x7, TIMEOUT_CYCLES=15 -> out_valid rises 15 cycles after HALF entry, out_data=0x07, out_partial=1; with TIMEOUT_CYCLES=0 -> no output ever.
REQ-033 The bench SHALL cover this scenario: 8 nibbles 0x1..0x8 queued, out_ready low 5 cycles after the first byte -> out_data held at 0x21, no pops in OUT, then bytes 0x21, 0x43, 0x65, 0x87 at a 2-cycle rate once ready.
REQ-034 The bench SHALL cover this scenario: read_reset pulsed in HALF holding 0x9 with empty=1 -> outputs 0 asynchronously, and the next pair 0x1, 0x2 yields 0x21.
REQ-035 The bench SHALL cover this scenario: READER_PARITY_EN defined, byte 0x5A -> out_parity=0; byte 0x07 partial -> out_parity=1.
